// File: rtl/add_norm_round_pkg.sv
// Shared FP16 definitions for the adder normalise/round stage.
package add_norm_round_pkg;

    localparam int FP16_W  = 16;
    localparam int EXP_W   = 5;
    localparam int FRAC_W  = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;
    localparam int SUM_W   = 13;
    localparam int IEXP_W  = 7;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  expo;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    // What kind of result stage 1 has decided on; stage 2 packs accordingly.
    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_FLUSH
    } sum_class_t;

    function automatic fp16_t fp16_pack(input logic sign,
                                        input logic [EXP_W-1:0] expo,
                                        input logic [FRAC_W-1:0] frac);
        fp16_t f;
        f.sign = sign;
        f.expo = expo;
        f.frac = frac;
        return f;
    endfunction

endpackage

// File: rtl/add_norm_round_lzc.sv
// 13-bit leading-zero counter; count is 13 and all_zero is set for a zero input.
module lzc_13b
    import add_norm_round_pkg::*;
(
    input  logic [SUM_W-1:0] value,
    output logic [3:0]       count,
    output logic             all_zero
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        count    = 4'd13;
        all_zero = (value == '0);
        for (int i = 0; i < SUM_W; i++) begin
            if (value[i]) begin
                count = 4'(12 - i);
            end
        end
    end

endmodule

// File: rtl/add_norm_round.sv
// FP16 add post-processing: stage 1 normalises the raw sum, stage 2 rounds
// to nearest even and packs the result.
// Optional feature macro: ADD_NORM_SUBNORM_EN (gradual underflow instead of flush-to-zero).
module add_norm_round
    import add_norm_round_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic              sign_in,
    input  logic [SUM_W-1:0]  frac_sum_in,
    input  logic              carry_in,
    input  logic [EXP_W-1:0]  exp_max_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [FP16_W-1:0] result_out,
    output logic              overflow_out,
    output logic              underflow_out
);

    logic                     s1_valid;
    logic                     s1_sign;
    logic [SUM_W-1:0]         s1_mant;
    logic signed [IEXP_W-1:0] s1_exp;
    sum_class_t               s1_class;

    logic                     advance;
    logic [3:0]               lz;
    logic                     frac_zero;

    logic signed [IEXP_W-1:0] e_eff;
    logic signed [IEXP_W-1:0] lz_s;
    logic [3:0]               shift;
    logic [SUM_W-1:0]         n_mant;
    logic signed [IEXP_W-1:0] n_exp;
    sum_class_t               n_class;

    logic                     inc;
    logic                     inexact;
    logic [11:0]              rnd;
    logic [10:0]              mant;
    logic signed [IEXP_W-1:0] exp_f;
    logic [EXP_W-1:0]         exp_field;
    fp16_t                    n_result;
    logic                     n_ov;
    logic                     n_uf;

    assign advance  = !valid_out || ready_out;
    assign ready_in = !s1_valid || advance;

    lzc_13b u_lzc (
        .value    (frac_sum_in),
        .count    (lz),
        .all_zero (frac_zero)
    );

    // Stage 1: pick the result class and normalise the magnitude so the
    // hidden bit lands in bit 12 (or as far as the exponent allows).
    always_comb begin
        n_class = CLS_NORMAL;
        n_mant  = '0;
        n_exp   = '0;
        shift   = lz;
        e_eff   = (exp_max_in == '0) ? 7'sd1 : $signed({2'b00, exp_max_in});
        lz_s    = $signed({3'b000, lz});
        if (exp_max_in == 5'(EXP_MAX)) begin
            n_class = CLS_INF;
        end else if (carry_in) begin
            n_mant = {1'b1, frac_sum_in[12:2], frac_sum_in[1] | frac_sum_in[0]};
            n_exp  = e_eff + 7'sd1;
        end else if (frac_zero) begin
            n_class = CLS_ZERO;
        end else begin
`ifdef ADD_NORM_SUBNORM_EN
            if (lz_s > e_eff - 7'sd1) begin
                shift = 4'(e_eff - 7'sd1);
                n_exp = 7'sd1;
            end else begin
                n_exp = e_eff - lz_s;
            end
            n_mant = frac_sum_in << shift;
`else
            n_mant = frac_sum_in << shift;
            n_exp  = e_eff - lz_s;
            if (n_exp < 7'sd1) begin
                n_class = CLS_FLUSH;
            end
`endif
        end
    end

    // Stage 1 register: loads whenever the stage is empty or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_class <= CLS_ZERO;
        end else if (ready_in) begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_sign  <= sign_in;
                s1_mant  <= n_mant;
                s1_exp   <= n_exp;
                s1_class <= n_class;
            end
        end
    end

    // Stage 2: round to nearest even, renormalise on carry, then pack with flags.
    always_comb begin
        inc       = s1_mant[1] & (s1_mant[0] | s1_mant[2]);
        inexact   = s1_mant[1] | s1_mant[0];
        rnd       = {1'b0, s1_mant[12:2]} + {11'b0, inc};
        mant      = rnd[10:0];
        exp_f     = s1_exp;
        if (rnd[11]) begin
            mant  = rnd[11:1];
            exp_f = s1_exp + 7'sd1;
        end
        exp_field = mant[10] ? exp_f[4:0] : '0;
        n_result  = '0;
        n_ov      = 1'b0;
        n_uf      = 1'b0;
        case (s1_class)
            CLS_INF: begin
                n_result = fp16_pack(s1_sign, 5'h1F, 10'h0);
            end
            CLS_ZERO: begin
                n_result = '0;
            end
            CLS_FLUSH: begin
                n_result = fp16_pack(s1_sign, 5'h0, 10'h0);
                n_uf     = 1'b1;
            end
            default: begin
                if (exp_f >= 7'sd31) begin
                    n_result = fp16_pack(s1_sign, 5'h1F, 10'h0);
                    n_ov     = 1'b1;
                end else begin
                    n_result = fp16_pack(s1_sign, exp_field, mant[9:0]);
                    n_uf     = (exp_field == '0) && inexact;
                end
            end
        endcase
    end

    // Output register: holds its contents while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out     <= 1'b0;
            result_out    <= '0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else if (advance) begin
            valid_out <= s1_valid;
            if (s1_valid) begin
                result_out    <= n_result;
                overflow_out  <= n_ov;
                underflow_out <= n_uf;
            end
        end
    end

endmodule
